// File: rtl/led_override.sv
// Manual/blink override in front of the LED bouncer; a hold timer returns control to the bouncer.
// Optional BLINK mode and blink counter are enabled by defining LED_OVERRIDE_BLINK_EN.
module led_override #(
  parameter int unsigned NLEDS     = 8,
  parameter int unsigned HOLDBITS  = 26,
  parameter int unsigned BLINKBITS = 23
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NLEDS-1:0] i_bounce,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [NLEDS-1:0] i_cmd_data,
  output logic [NLEDS-1:0] o_leds,
  output logic             o_manual
);

  typedef enum logic [1:0] {
    StBounce = 2'd0,
`ifdef LED_OVERRIDE_BLINK_EN
    StManual = 2'd1,
    StBlink  = 2'd2
`else
    StManual = 2'd1
`endif
  } state_e;

  localparam logic [1:0] OpRelease = 2'b00;
  localparam logic [1:0] OpSet     = 2'b01;
`ifdef LED_OVERRIDE_BLINK_EN
  localparam logic [1:0] OpBlink   = 2'b10;
`endif

  state_e              state_q;
  logic [NLEDS-1:0]    pattern_q;
  logic [HOLDBITS-1:0] hold_q;
  logic [NLEDS-1:0]    leds_d;
  logic                accept;

`ifdef LED_OVERRIDE_BLINK_EN
  logic [BLINKBITS-1:0] blink_cnt_q;
  logic                 blink_phase;
  assign blink_phase = blink_cnt_q[BLINKBITS-1];
`else
  localparam int unsigned BlinkBitsUnused = BLINKBITS;
  logic [BlinkBitsUnused-1:0] blink_tie;
  assign blink_tie = '0;
  logic unused_blink;
  assign unused_blink = ^blink_tie;
`endif

  assign accept = i_cmd_valid && o_cmd_ready;

  // LED drive is computed from the pre-edge state and pattern.
  always_comb begin
    leds_d = i_bounce;
    case (state_q)
      StBounce: leds_d = i_bounce;
      StManual: leds_d = pattern_q;
`ifdef LED_OVERRIDE_BLINK_EN
      StBlink:  leds_d = blink_phase ? '0 : pattern_q;
`endif
      default:  leds_d = i_bounce;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StBounce;
      pattern_q   <= '0;
      hold_q      <= '0;
      o_leds      <= '0;
      o_manual    <= 1'b0;
      o_cmd_ready <= 1'b0;
`ifdef LED_OVERRIDE_BLINK_EN
      blink_cnt_q <= '0;
`endif
    end else begin
      o_leds      <= leds_d;
      o_manual    <= (state_q != StBounce);
      o_cmd_ready <= !accept;
`ifdef LED_OVERRIDE_BLINK_EN
      blink_cnt_q <= blink_cnt_q + 1'b1;
`endif
      if (accept) begin
        case (i_cmd_op)
          OpRelease: state_q <= StBounce;
          OpSet: begin
            pattern_q <= i_cmd_data;
            state_q   <= StManual;
            hold_q    <= '1;
          end
`ifdef LED_OVERRIDE_BLINK_EN
          OpBlink: begin
            pattern_q   <= i_cmd_data;
            state_q     <= StBlink;
            hold_q      <= '1;
            blink_cnt_q <= '0;
          end
`endif
          // Reserved op (and blink when disabled): handshake only, all state frozen.
          default: begin
`ifdef LED_OVERRIDE_BLINK_EN
            blink_cnt_q <= blink_cnt_q;
`endif
          end
        endcase
      end else if (state_q != StBounce) begin
        if (hold_q == '0) begin
          state_q <= StBounce;
        end else begin
          hold_q <= hold_q - 1'b1;
        end
      end
    end
  end

endmodule
